// File: rtl/l2_cacheline_adaptor.sv
// rtl/l2_cacheline_adaptor.sv - 256-bit L2 line to 64-bit pmem burst adaptor
//
// Converts one L2 line transaction into a BEATS-long pmem burst. A read
// gathers BEATS beats into line_o. A write streams the latched line out on
// burst_o. One resp_o pulse marks the end of each line transaction.
//
// Optional feature macro: L2_ADAPTOR_TIMEOUT_EN
//   defined   : per-beat wait counter. Reaching TIMEOUT_CYCLES sets sticky
//               error_o and ends the transaction through DONE.
//   undefined : error_o tied low. The FSM waits for resp_i indefinitely.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   line_i / line_o     256-bit write line from L2 / assembled read line to L2
//   address_i           L2 line address, bits [4:0] ignored
//   read_i / write_i    L2 line requests, held until resp_o
//   resp_o              one-cycle line-complete pulse to L2
//   burst_i / burst_o   64-bit pmem read beat / write beat
//   address_o           line-aligned pmem address
//   read_o / write_o    pmem read / write strobes
//   resp_i              pmem per-beat accept/valid
//   error_o             sticky timeout flag
module l2_cacheline_adaptor #(
  parameter int BEATS          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i,
  output logic         error_o
);

  // The beat counter is 2 bits wide, and the wait counter is 8 bits wide.
  // Reject configurations that cannot fit.
  if (BEATS != 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("l2_cacheline_adaptor: BEATS must be 4 and TIMEOUT_CYCLES 1..255");
  end

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                 state, state_next;
  logic [1:0]             cnt;
  logic [26:0]            addr_q;
  logic [BEATS-1:0][63:0] wline_q;
  logic [BEATS-1:0][63:0] rline_q;
  logic                   timeout;

  // Line-offset bits are dropped on purpose.
  logic unused_offset;
  assign unused_offset = ^address_i[4:0];

  assign address_o = {addr_q, 5'b0};
  assign line_o    = rline_q;

`ifdef L2_ADAPTOR_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_cnt;
  logic       error_q;

  assign timeout = (wait_cnt == TIMEOUT_LIMIT);
  assign error_o = error_q;

  // The counter restarts on every state change and on every accepted beat.
  // It therefore measures the wait for the beat currently outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      if (state_next != state || resp_i) begin
        wait_cnt <= '0;
      end else if (state == RD || state == WR) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if ((state == RD || state == WR) && !resp_i && timeout) begin
        error_q <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (write_i) begin
            addr_q  <= address_i[31:5];
            wline_q <= line_i;
          end else if (read_i) begin
            addr_q <= address_i[31:5];
          end
        end
        RD: begin
          if (resp_i) begin
            rline_q[cnt] <= burst_i;
            cnt          <= cnt + 2'd1;
          end
        end
        WR: begin
          if (resp_i) begin
            cnt <= cnt + 2'd1;
          end
        end
        DONE: cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  // Next-state logic and Moore output decode.
  // A beat arriving on the same cycle as a timeout still counts as a beat.
  always_comb begin
    state_next = state;
    read_o     = 1'b0;
    write_o    = 1'b0;
    resp_o     = 1'b0;
    burst_o    = '0;
    case (state)
      IDLE: begin
        if (write_i) begin
          state_next = WR;
        end else if (read_i) begin
          state_next = RD;
        end
      end
      RD: begin
        read_o = 1'b1;
        if (resp_i) begin
          if (cnt == LAST_BEAT) state_next = DONE;
        end else if (timeout) begin
          state_next = DONE;
        end
      end
      WR: begin
        write_o = 1'b1;
        burst_o = wline_q[cnt];
        if (resp_i) begin
          if (cnt == LAST_BEAT) state_next = DONE;
        end else if (timeout) begin
          state_next = DONE;
        end
      end
      DONE: begin
        resp_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// tb/tb_l2_cacheline_adaptor.sv - self-checking bench for l2_cacheline_adaptor
module tb_l2_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;
  logic         error_o;

  l2_cacheline_adaptor #(.BEATS(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  int resp_total = 0;
  int txn_expected = 0;
  logic [255:0] last_line = '0;   // model: line_o holds last completed read line

  always @(negedge clk) if (rst === 1'b1 && resp_o === 1'b1) resp_total++;

  typedef struct {
    bit           wr;
    bit           rd;
    logic [31:0]  addr;
    logic [255:0] wline;
    logic [255:0] rline;
    int           gap;
    logic [31:0]  exp_addr;
  } vec_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Runs one line transaction from an IDLE cycle and checks every cycle until resp_o.
  // gap >= 0: beat on every (gap+1)th cycle; gap < 0: random spacing, at most 3 idle cycles.
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] rline,
                         input int gap, input logic [31:0] exp_addr);
    int  beat = 0;
    int  idle = 0;
    bit  done = 0;
    bit  issue;
    @(negedge clk);
    check("resp_single", resp_o, 1'b0);
    address_i = addr; line_i = wline; write_i = wr; read_i = rd;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      resp_i = 1'b0;
      if (beat == 4) begin
        check("resp_after_last_beat", resp_o, 1'b1);
        done = 1;
        break;
      end
      check("resp_early", resp_o, 1'b0);
      check("address_o", address_o, exp_addr);
      check("read_o", read_o, !wr);
      check("write_o", write_o, wr);
      if (wr) check("burst_o_lane", burst_o, wline[64*beat +: 64]);
      if (gap >= 0) issue = ((cyc % (gap + 1)) == gap);
      else          issue = (idle >= 3) || ($urandom_range(0, 2) == 0);
      if (issue) begin
        resp_i = 1'b1; burst_i = rline[64*beat +: 64]; beat++; idle = 0;
      end else begin
        burst_i = {$urandom, $urandom}; idle++;
      end
    end
    if (!done) check("txn_cycle_budget", 1'b0, 1'b1);
    read_i = 1'b0; write_i = 1'b0;
    if (!wr) last_line = rline;
    txn_expected++;
    check("line_o", line_o, last_line);
    check("error_o", error_o, 1'b0);
  endtask

  vec_t vecs[4];

  initial begin
    logic [255:0] ramp;
    logic [255:0] abeats;
    logic [255:0] nl;
    int           rd_hi;
    for (int k = 0; k < 32; k++) ramp[8*k +: 8] = 8'(k);
    abeats = {64'hA3, 64'hA2, 64'hA1, 64'hA0};

    vecs[0] = '{wr:0, rd:1, addr:32'h1234_5678, wline:'0,   rline:abeats, gap:0, exp_addr:32'h1234_5660};
    vecs[1] = '{wr:1, rd:0, addr:32'h0000_0040, wline:ramp, rline:'0,     gap:1, exp_addr:32'h0000_0040};
    vecs[2] = '{wr:1, rd:1, addr:32'hFFFF_FFFF, wline:~ramp, rline:'0,    gap:0, exp_addr:32'hFFFF_FFE0};
    vecs[3] = '{wr:0, rd:1, addr:32'h0000_001F, wline:'0,   rline:~abeats, gap:2, exp_addr:32'h0000_0000};

    rst = 1'b0; line_i = '0; address_i = '0; read_i = 0; write_i = 0; burst_i = '0; resp_i = 0;
    #1;
    check("reset_line_o", line_o, '0);
    check("reset_address_o", address_o, '0);
    check("reset_burst_o", burst_o, '0);
    check("reset_strobes", {read_o, write_o, resp_o, error_o}, 4'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Directed table, back-to-back with no spare IDLE cycles.
    for (int i = 0; i < 4; i++)
      run_txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wline, vecs[i].rline, vecs[i].gap, vecs[i].exp_addr);

    // Reset after two read beats abandons the burst at once.
    @(negedge clk);
    address_i = 32'hCAFE_BABE; read_i = 1'b1;
    @(negedge clk); resp_i = 1'b1; burst_i = 64'h1111;
    @(negedge clk); burst_i = 64'h2222;
    @(negedge clk); resp_i = 1'b0;
    check("pre_reset_read_o", read_o, 1'b1);
    rst = 1'b0; read_i = 1'b0;
    #1;
    check("midburst_reset_strobes", {read_o, write_o, resp_o, error_o}, 4'b0);
    check("midburst_reset_line_o", line_o, '0);
    check("midburst_reset_address_o", address_o, '0);
    last_line = '0;
    @(negedge clk); rst = 1'b1;
    nl = {64'h4, 64'h3, 64'h2, 64'h1};
    run_txn(0, 1, 32'h0000_1000, '0, nl, 0, 32'h0000_1000);

    // Random transactions against the reference model.
    for (int t = 0; t < 30; t++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = $urandom;
      run_txn(kind >= 2, kind != 2, a, rand256(), rand256(), -1, a - (a % 32));
    end

    // Long silence from pmem.
    @(negedge clk);
    check("resp_single_pre_wait", resp_o, 1'b0);
    address_i = 32'h0BAD_F00D; read_i = 1'b1;
    rd_hi = 0;
`ifdef L2_ADAPTOR_TIMEOUT_EN
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (read_o === 1'b1 && resp_o === 1'b0) rd_hi++;
    end
    check("timeout_wait_cycles", 32'(rd_hi), 32'd9);
    @(negedge clk);
    check("timeout_resp_o", resp_o, 1'b1);
    check("timeout_error_o", error_o, 1'b1);
    read_i = 1'b0;
    txn_expected++;
    check("timeout_line_kept", line_o, last_line);
    @(negedge clk);
    check("timeout_resp_single", resp_o, 1'b0);
    check("error_sticky", error_o, 1'b1);
`else
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (read_o === 1'b1 && resp_o === 1'b0 && error_o === 1'b0) rd_hi++;
    end
    check("no_timeout_stays_rd", 32'(rd_hi), 32'd20);
    nl = rand256();
    for (int b = 0; b < 4; b++) begin
      resp_i = 1'b1; burst_i = nl[64*b +: 64];
      @(negedge clk);
    end
    resp_i = 1'b0;
    check("late_beats_resp_o", resp_o, 1'b1);
    read_i = 1'b0;
    txn_expected++;
    last_line = nl;
    check("late_beats_line_o", line_o, last_line);
    @(negedge clk);
    check("late_beats_resp_single", resp_o, 1'b0);
`endif

    @(negedge clk);
    check("resp_pulse_count", 32'(resp_total), 32'(txn_expected));
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
